// File: rtl/mem_bus_if_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_if_if : control-unit and external-memory handshake bundle for mem_bus_if
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_bus_if_if #(
  parameter int w = 32
) ();
  logic         MAin;
  logic         MDin;
  logic         MDout;
  logic         Read;
  logic         Write;
  logic [w-1:0] mem_addr;
  logic [w-1:0] mem_wdata;
  logic [w-1:0] mem_rdata;
  logic         mem_req;
  logic         mem_we;
  logic         mem_ack;
  logic         done;
  logic         busy;
  logic         err;

  modport slave (
    input  MAin, MDin, MDout, Read, Write, mem_rdata, mem_ack,
    output mem_addr, mem_wdata, mem_req, mem_we, done, busy, err
  );

  modport master (
    output MAin, MDin, MDout, Read, Write, mem_rdata, mem_ack,
    input  mem_addr, mem_wdata, mem_req, mem_we, done, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_if : MA/MD registers on the shared CPU bus with a req/ack memory FSM
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_bus_if #(
  parameter int w       = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  inout  wire [w-1:0] bus,
  mem_bus_if_if.slave cpu
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                 c_to_en    = (TIMEOUT > 0);

  state_t               state_q, state_d;
  logic [w-1:0]         ma_q, ma_d;
  logic [w-1:0]         md_q, md_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 w_timeout;

  // Last waiting cycle; an ack on this same edge still wins over the abort
  assign w_timeout = c_to_en && (cnt_q == c_cnt_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    md_d    = md_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu.MAin) begin
          ma_d = bus;
        end
        // With MDout also set the bus already carries MD, so leave it untouched
        if (cpu.MDin && !cpu.MDout) begin
          md_d = bus;
        end
        if (cpu.Read && cpu.Write) begin
          err_d = 1'b1;
        end else if (cpu.Read) begin
          state_d = S_RD_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b0;
        end else if (cpu.Write) begin
          state_d = S_WR_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b1;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (cpu.mem_ack) begin
          if (state_q == S_RD_WAIT) begin
            md_d = cpu.mem_rdata;
          end
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else if (w_timeout) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  assign bus           = cpu.MDout ? md_q : {w{1'bz}};
  assign cpu.mem_addr  = ma_q;
  assign cpu.mem_wdata = md_q;
  assign cpu.mem_req   = req_q;
  assign cpu.mem_we    = we_q;
  assign cpu.done      = done_q;
  assign cpu.err       = err_q;
  assign cpu.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_if : vector table, hand sequences and randomized transactions
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_bus_if;
  localparam int W  = 32;
  localparam int TO = 8;

  localparam int OP_LDMA = 0;
  localparam int OP_LDMD = 1;
  localparam int OP_RD   = 2;
  localparam int OP_WR   = 3;
  localparam int OP_ILL  = 4;
  localparam int NV      = 10;

  typedef struct {
    int           op;
    logic [W-1:0] data;
    int           delay;
    logic [W-1:0] exp_ma;
    logic [W-1:0] exp_md;
    bit           exp_done;
    bit           exp_err;
    int           exp_reqc;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         drive_bus;
  logic [W-1:0] bus_val;
  wire  [W-1:0] bus;

  assign bus = drive_bus ? bus_val : {W{1'bz}};

  mem_bus_if_if #(.w(W)) cpu ();

  mem_bus_if #(.w(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .cpu (cpu)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] m_ma;
  logic [W-1:0] m_md;
  vec_t         tbl [NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    cpu.MAin      = 1'b0;
    cpu.MDin      = 1'b0;
    cpu.MDout     = 1'b0;
    cpu.Read      = 1'b0;
    cpu.Write     = 1'b0;
    cpu.mem_ack   = 1'b0;
    cpu.mem_rdata = $urandom;
    drive_bus     = 1'b0;
    bus_val       = '0;
  endtask

  task automatic load(input bit to_ma, input logic [W-1:0] v);
    drive_bus = 1'b1;
    bus_val   = v;
    cpu.MAin  = to_ma;
    cpu.MDin  = !to_ma;
    tick();
    idle_in();
  endtask

  // Issues one command from IDLE and acts as memory, acking 'delay' cycles after req rises
  task automatic run_xact(input int op, input int delay, input logic [W-1:0] rdata,
                          input logic [W-1:0] exp_addr, input logic [W-1:0] exp_wd,
                          output bit got_done, output bit got_err, output int reqc);
    cpu.Read  = (op != OP_WR);
    cpu.Write = (op != OP_RD);
    tick();
    cpu.Read  = 1'b0;
    cpu.Write = 1'b0;
    got_done  = (cpu.done === 1'b1);
    got_err   = (cpu.err === 1'b1);
    reqc      = 0;
    for (int k = 0; k < 40; k++) begin
      if (cpu.mem_req !== 1'b1) break;
      reqc++;
      chk("we_hold", W'(cpu.mem_we), W'(op == OP_WR));
      chk("addr_hold", cpu.mem_addr, exp_addr);
      chk("wdata_hold", cpu.mem_wdata, exp_wd);
      if (k == delay) begin
        cpu.mem_ack   = 1'b1;
        cpu.mem_rdata = rdata;
      end
      tick();
      cpu.mem_ack   = 1'b0;
      cpu.mem_rdata = $urandom;
      if (cpu.done === 1'b1) got_done = 1'b1;
      if (cpu.err === 1'b1)  got_err  = 1'b1;
      chk("done_err_excl", W'(cpu.done & cpu.err), '0);
    end
    tick();
    chk("done_pulse", W'(cpu.done), '0);
    chk("err_pulse", W'(cpu.err), '0);
    chk("idle_busy", W'(cpu.busy), '0);
  endtask

  initial begin
    bit gd, ge, ok;
    int rc, op, dly;
    logic [W-1:0] rd;

    tbl[0] = '{OP_LDMA, 32'h0000_000F, 0,  32'h0000_000F, 32'h0000_0000, 1'b0, 1'b0, 0};
    tbl[1] = '{OP_RD,   32'hDEAD_BEEF, 3,  32'h0000_000F, 32'hDEAD_BEEF, 1'b1, 1'b0, 4};
    tbl[2] = '{OP_LDMD, 32'h1234_5678, 0,  32'h0000_000F, 32'h1234_5678, 1'b0, 1'b0, 0};
    tbl[3] = '{OP_LDMA, 32'h0000_0040, 0,  32'h0000_0040, 32'h1234_5678, 1'b0, 1'b0, 0};
    tbl[4] = '{OP_WR,   32'hFFFF_0000, 1,  32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0, 2};
    tbl[5] = '{OP_RD,   32'hBAD0_BAD0, 20, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1, 8};
    tbl[6] = '{OP_ILL,  32'h0000_0000, 0,  32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1, 0};
    tbl[7] = '{OP_RD,   32'hA5A5_0001, 0,  32'h0000_0040, 32'hA5A5_0001, 1'b1, 1'b0, 1};
    tbl[8] = '{OP_RD,   32'h0000_7777, 7,  32'h0000_0040, 32'h0000_7777, 1'b1, 1'b0, 8};
    tbl[9] = '{OP_WR,   32'h0000_0000, 8,  32'h0000_0040, 32'h0000_7777, 1'b0, 1'b1, 8};

    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ma", cpu.mem_addr, '0);
    chk("rst_md", cpu.mem_wdata, '0);
    chk("rst_req", W'(cpu.mem_req), '0);
    chk("rst_we", W'(cpu.mem_we), '0);
    chk("rst_done", W'(cpu.done), '0);
    chk("rst_err", W'(cpu.err), '0);
    chk("rst_busy", W'(cpu.busy), '0);
    m_ma = '0;
    m_md = '0;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].op == OP_LDMA) begin
        load(1'b1, tbl[i].data);
      end else if (tbl[i].op == OP_LDMD) begin
        load(1'b0, tbl[i].data);
      end else begin
        run_xact(tbl[i].op, tbl[i].delay, tbl[i].data, m_ma, m_md, gd, ge, rc);
        chk($sformatf("vec%0d_done", i), W'(gd), W'(tbl[i].exp_done));
        chk($sformatf("vec%0d_err", i), W'(ge), W'(tbl[i].exp_err));
        chk($sformatf("vec%0d_reqc", i), W'(rc), W'(tbl[i].exp_reqc));
      end
      chk($sformatf("vec%0d_ma", i), cpu.mem_addr, tbl[i].exp_ma);
      chk($sformatf("vec%0d_md", i), cpu.mem_wdata, tbl[i].exp_md);
      if (tbl[i].op == OP_RD && tbl[i].exp_done) begin
        cpu.MDout = 1'b1;
        #1;
        chk($sformatf("vec%0d_bus", i), bus, tbl[i].exp_md);
        cpu.MDout = 1'b0;
      end
      m_ma = tbl[i].exp_ma;
      m_md = tbl[i].exp_md;
    end

    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          rd = $urandom;
          load(1'b1, rd);
          m_ma = rd;
          chk("rnd_ma", cpu.mem_addr, m_ma);
        end
        1: begin
          rd = $urandom;
          load(1'b0, rd);
          m_md = rd;
          chk("rnd_md", cpu.mem_wdata, m_md);
        end
        2, 3: begin
          dly = $urandom_range(0, 11);
          rd  = $urandom;
          run_xact((op == 2) ? OP_RD : OP_WR, dly, rd, m_ma, m_md, gd, ge, rc);
          ok = (dly < TO);
          if (op == 2 && ok) m_md = rd;
          chk("rnd_done", W'(gd), W'(ok));
          chk("rnd_err", W'(ge), W'(!ok));
          chk("rnd_reqc", W'(rc), W'(ok ? dly + 1 : TO));
          chk("rnd_xact_md", cpu.mem_wdata, m_md);
        end
        4: begin
          cpu.MDout = 1'b1;
          cpu.MDin  = 1'b1;
          #1;
          chk("rnd_bus", bus, m_md);
          tick();
          idle_in();
          chk("rnd_mdout_mdin", cpu.mem_wdata, m_md);
        end
        default: begin
          run_xact(OP_ILL, 0, '0, m_ma, m_md, gd, ge, rc);
          chk("rnd_ill_err", W'(ge), 1);
          chk("rnd_ill_done", W'(gd), 0);
          chk("rnd_ill_reqc", W'(rc), 0);
        end
      endcase
    end

    // Reset two cycles into a read, then a stray ack
    load(1'b1, 32'h0000_0123);
    load(1'b0, 32'h0000_0456);
    cpu.Read = 1'b1;
    tick();
    cpu.Read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", W'(cpu.mem_req), '0);
    chk("mid_rst_busy", W'(cpu.busy), '0);
    chk("mid_rst_ma", cpu.mem_addr, '0);
    chk("mid_rst_md", cpu.mem_wdata, '0);
    chk("mid_rst_done", W'(cpu.done), '0);
    cpu.mem_ack   = 1'b1;
    cpu.mem_rdata = 32'hFFFF_FFFF;
    tick();
    cpu.mem_ack = 1'b0;
    chk("late_ack_done", W'(cpu.done), '0);
    chk("late_ack_md", cpu.mem_wdata, '0);
    chk("late_ack_req", W'(cpu.mem_req), '0);

    // MAin/MDin/Read while in RD_WAIT are ignored
    load(1'b1, 32'h0000_0010);
    cpu.Read = 1'b1;
    tick();
    cpu.Read  = 1'b0;
    drive_bus = 1'b1;
    bus_val   = 32'h0000_0099;
    cpu.MAin  = 1'b1;
    cpu.MDin  = 1'b1;
    cpu.Read  = 1'b1;
    tick();
    idle_in();
    chk("blk_ma", cpu.mem_addr, 32'h0000_0010);
    chk("blk_md", cpu.mem_wdata, '0);
    chk("blk_req", W'(cpu.mem_req), 1);
    cpu.mem_ack   = 1'b1;
    cpu.mem_rdata = 32'hCAFE_0000;
    tick();
    cpu.mem_ack = 1'b0;
    chk("blk_done", W'(cpu.done), 1);
    chk("blk_rd_md", cpu.mem_wdata, 32'hCAFE_0000);
    tick();
    chk("blk_no_2nd_req", W'(cpu.mem_req), '0);
    chk("blk_busy", W'(cpu.busy), '0);

    // Write accepted in the same cycle done is high
    cpu.Read = 1'b1;
    tick();
    cpu.Read      = 1'b0;
    cpu.mem_ack   = 1'b1;
    cpu.mem_rdata = 32'h1111_2222;
    tick();
    cpu.mem_ack = 1'b0;
    chk("b2b_done1", W'(cpu.done), 1);
    cpu.Write = 1'b1;
    tick();
    cpu.Write = 1'b0;
    chk("b2b_req", W'(cpu.mem_req), 1);
    chk("b2b_we", W'(cpu.mem_we), 1);
    chk("b2b_busy", W'(cpu.busy), 1);
    chk("b2b_wdata", cpu.mem_wdata, 32'h1111_2222);
    cpu.mem_ack = 1'b1;
    tick();
    cpu.mem_ack = 1'b0;
    chk("b2b_done2", W'(cpu.done), 1);
    chk("b2b_we_low", W'(cpu.mem_we), '0);
    chk("b2b_md", cpu.mem_wdata, 32'h1111_2222);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
